// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes them to
// consecutive instruction-RAM addresses, holding the CPU in reset until the image is in.
module imem_loader #(
    parameter int unsigned N  = 32,
    parameter int unsigned AW = 6
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [AW:0]   word_count_i,
    input  logic [7:0]    byte_in_i,
    input  logic          byte_valid_i,
    output logic          byte_ready_o,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [N-1:0]  wdata_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          cpu_reset_o
);

    localparam int unsigned Depth    = 1 << AW;
    localparam logic [AW:0] MaxCount = (AW + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   words_q, words_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [AW:0]   count_clamped;

    // Requests beyond the memory depth are clamped so the address never wraps.
    assign count_clamped = (word_count_i > MaxCount) ? MaxCount : word_count_i;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        words_d    = words_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        byte_cnt_d = byte_cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    count_d    = count_clamped;
                    words_d    = '0;
                    waddr_d    = '0;
                    byte_cnt_d = '0;
                    state_d    = (count_clamped == '0) ? StDone : StRecv;
                end
            end
            StRecv: begin
                if (byte_valid_i) begin
                    wdata_d[{byte_cnt_q, 3'b000} +: 8] = byte_in_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                words_d    = words_q + 1'b1;
                byte_cnt_d = '0;
                if (words_d == count_q) begin
                    state_d = StDone;
                end else begin
                    waddr_d = waddr_q + 1'b1;
                    state_d = StRecv;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            count_q    <= '0;
            words_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            words_q    <= words_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // All handshake/status outputs decode from state alone: no valid->ready path.
    assign byte_ready_o = (state_q == StRecv);
    assign we_o         = (state_q == StWrite);
    assign busy_o       = (state_q == StRecv) || (state_q == StWrite);
    assign done_o       = (state_q == StDone);
    assign cpu_reset_o  = (state_q != StDone);
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart of the instruction ROM: turns a byte stream into 32-bit instruction words and writes them into a writable instruction memory at consecutive word addresses.
- Sits between a boot byte source (UART/debug FIFO) and the instruction RAM.
- Holds the processor in reset until the programme image is fully loaded.

Parameters:
N, 32, instruction word width in bits (must be 32; 4 bytes per word)
AW, 6, word address width; memory depth is 2**AW = 64 words

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a load (sampled only in IDLE or DONE)
word_count  in  AW+1  number of words to load, latched on accepted start
byte_in  in  8  incoming byte
byte_valid  in  1  byte_in valid
byte_ready  out  1  loader can accept a byte this cycle
we  out  1  memory write enable, one-cycle pulse per word
waddr  out  AW  memory word address
wdata  out  N  memory write data
busy  out  1  load in progress
done  out  1  load complete, held until next start or reset
cpu_reset  out  1  active-high reset to processor

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, cpu_reset=1.
  - Byte counter and word counter cleared.
  - Applies mid-load; a partial word is discarded.
- States: IDLE, RECV, WRITE, DONE. Outputs are registered or decoded from state only; there is no combinational path from byte_valid to byte_ready.
- IDLE:
  - cpu_reset=1, byte_ready=0.
  - On start: latch count = min(word_count, 64).
  - count=0 -> DONE next cycle, no write.
  - Else -> RECV with waddr=0 and byte counter=0.
- RECV:
  - busy=1, byte_ready=1, cpu_reset=1.
  - A byte transfers on a cycle with byte_valid=1 and byte_ready=1.
  - Little-endian assembly: byte k (k=0..3) goes to wdata[8k+7:8k].
  - The transfer of byte 3 moves the state to WRITE; byte_ready=0 in the following cycle.
  - Gaps in byte_valid simply stall; there is no timeout.
- WRITE:
  - we=1 for exactly one cycle with the current waddr and the assembled wdata.
  - byte_ready=0.
  - Next cycle: if words written == count -> DONE, waddr unchanged; else waddr+1, byte counter=0 -> RECV.
- DONE:
  - done=1, busy=0, cpu_reset=0, byte_ready=0, we=0.
  - start -> same handling as IDLE (reload); done and cpu_reset return to 0/1 the cycle after start.
- start in RECV or WRITE is ignored.
- Bytes offered outside RECV are not accepted (byte_ready=0); the source must hold them.
- Latency:
  - Minimum 5 cycles per word: 4 accept cycles plus 1 write cycle.
  - done rises the cycle after the final WRITE cycle.
  - A count=0 load reaches DONE 1 cycle after start.
- Address never wraps: at most 64 writes, last waddr=63; word_count>64 clamps to 64.
- word_count is sampled only on the start cycle; later changes have no effect.

Test Plan:
- Basic load: start with word_count=2, bytes 01 00 00 F8 02 80 00 F8 (byte_valid held high).
  - we at waddr 0 with wdata=F8000001; we at waddr 1 with F8008002.
  - done=1 and cpu_reset=0 in the cycle after the second write; exactly 2 we pulses.
- Gapped stream: same image with byte_valid toggling 1/0 every cycle.
  - Identical writes and data.
  - No byte is accepted while byte_ready=0.
  - No we before the 4th byte of each word.
- Boundaries:
  - word_count=0 -> done next cycle, no we.
  - word_count=64 -> 64 writes, last at waddr=63.
  - word_count=100 -> clamped to 64 writes, no wrap to 0.
- Reset mid-load: assert reset after 2 bytes of word 1.
  - Outputs immediately at their reset values.
  - A new start with word_count=1 and bytes AA BB CC DD writes DDCCBBAA at waddr 0.
- Control robustness:
  - start pulsed during RECV -> ignored; count and waddr unchanged.
  - After DONE, start with word_count=1 -> cpu_reset=1 and done=0 next cycle.
  - The reload writes waddr 0 and returns to DONE.
